// File: rtl/ysyx_22040088_mem_arbiter_pkg.sv
// Shared types for the instruction-fetch / load-store memory arbiter.
//   state_t : transaction FSM states (IDLE, ISSUE, WAIT, RESP)
//   owner_t : which requester owns the outstanding transaction
//   DEF_*   : default address/data widths
package ysyx_22040088_mem_arbiter_pkg;

  localparam int DEF_ADDR_W = 64;
  localparam int DEF_DATA_W = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_t;

endpackage

// File: rtl/ysyx_22040088_rr_arb2.sv
// Two-input round-robin arbiter with its own last-grant register.
//   clk     : clock, rising edge
//   rst_n   : asynchronous active-low reset (last grant returns to IF)
//   i_en    : accept enable; no grant is issued while low
//   i_req   : request vector, bit 0 = IF, bit 1 = LS
//   o_gnt   : one-hot grant, combinational from i_req / i_en
module ysyx_22040088_rr_arb2
  import ysyx_22040088_mem_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_en,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt
);

  owner_t r_last;
  logic   w_pick_ls;

  always_comb begin
    w_pick_ls = 1'b0;
    o_gnt     = 2'b00;
    if (i_req == 2'b10) begin
      w_pick_ls = 1'b1;
    end else if (i_req == 2'b11) begin
      // Tie: favour whoever was not granted last.
      w_pick_ls = (r_last == OWN_IF);
    end
    if (i_en && (i_req != 2'b00)) begin
      o_gnt = w_pick_ls ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= OWN_IF;
    end else if (o_gnt != 2'b00) begin
      r_last <= o_gnt[1] ? OWN_LS : OWN_IF;
    end
  end

endmodule

// File: rtl/ysyx_22040088_mem_arbiter.sv
// Arbitrates an instruction-fetch port and a load/store port onto a single
// memory port with at most one transaction outstanding.
//   clk, rst                 : clock; asynchronous active-low reset
//   if_req_* / if_addr       : fetch request handshake and address
//   if_rsp_valid / if_rdata  : one-cycle fetch response pulse and held data
//   ls_req_* / ls_*          : load/store request handshake and fields
//   ls_rsp_valid / ls_rdata  : one-cycle load/store response pulse and held data
//   mem_req_* / mem_*        : memory request handshake and latched fields
//   mem_rsp_valid/mem_rdata  : memory response
module ysyx_22040088_mem_arbiter
  import ysyx_22040088_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req_valid,
  output logic                if_req_ready,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_rsp_valid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                ls_req_valid,
  output logic                ls_req_ready,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic                ls_wen,
  input  logic [DATA_W/8-1:0] ls_wmask,
  input  logic [DATA_W-1:0]   ls_wdata,
  output logic                ls_rsp_valid,
  output logic [DATA_W-1:0]   ls_rdata,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wen,
  output logic [DATA_W/8-1:0] mem_wmask,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_rsp_valid,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int MASK_W = DATA_W / 8;

  state_t              r_state;
  owner_t              r_owner;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_wen;
  logic [MASK_W-1:0]   r_wmask;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_mem_req_valid;
  logic                r_if_rsp_valid;
  logic                r_ls_rsp_valid;
  logic [DATA_W-1:0]   r_if_rdata;
  logic [DATA_W-1:0]   r_ls_rdata;

  logic                w_idle;
  logic [1:0]          w_gnt;

  assign w_idle = (r_state == IDLE);

  // Grants are only possible in IDLE, so the ready outputs double as accepts.
  ysyx_22040088_rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst),
    .i_en  (w_idle),
    .i_req ({ls_req_valid, if_req_valid}),
    .o_gnt (w_gnt)
  );

  assign if_req_ready  = w_gnt[0];
  assign ls_req_ready  = w_gnt[1];
  assign mem_req_valid = r_mem_req_valid;
  assign mem_addr      = r_addr;
  assign mem_wen       = r_wen;
  assign mem_wmask     = r_wmask;
  assign mem_wdata     = r_wdata;
  assign if_rsp_valid  = r_if_rsp_valid;
  assign ls_rsp_valid  = r_ls_rsp_valid;
  assign if_rdata      = r_if_rdata;
  assign ls_rdata      = r_ls_rdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state         <= IDLE;
      r_owner         <= OWN_IF;
      r_addr          <= '0;
      r_wen           <= 1'b0;
      r_wmask         <= '0;
      r_wdata         <= '0;
      r_mem_req_valid <= 1'b0;
      r_if_rsp_valid  <= 1'b0;
      r_ls_rsp_valid  <= 1'b0;
      r_if_rdata      <= '0;
      r_ls_rdata      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_gnt[1]) begin
            r_state         <= ISSUE;
            r_mem_req_valid <= 1'b1;
            r_owner         <= OWN_LS;
            r_addr          <= ls_addr;
            r_wen           <= ls_wen;
            r_wmask         <= ls_wmask;
            r_wdata         <= ls_wdata;
          end else if (w_gnt[0]) begin
            // Fetches are always reads with no byte enables.
            r_state         <= ISSUE;
            r_mem_req_valid <= 1'b1;
            r_owner         <= OWN_IF;
            r_addr          <= if_addr;
            r_wen           <= 1'b0;
            r_wmask         <= '0;
            r_wdata         <= '0;
          end
        end
        ISSUE: begin
          if (mem_req_ready) begin
            r_mem_req_valid <= 1'b0;
            r_state         <= WAIT;
          end
        end
        WAIT: begin
          // Responses in any other state fall through untouched.
          if (mem_rsp_valid) begin
            r_state <= RESP;
            if (r_owner == OWN_LS) begin
              r_ls_rdata     <= mem_rdata;
              r_ls_rsp_valid <= 1'b1;
            end else begin
              r_if_rdata     <= mem_rdata;
              r_if_rsp_valid <= 1'b1;
            end
          end
        end
        RESP: begin
          r_if_rsp_valid <= 1'b0;
          r_ls_rsp_valid <= 1'b0;
          r_state        <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22040088_mem_arbiter.sv
module tb_ysyx_22040088_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req_valid = 1'b0;
  logic        if_req_ready;
  logic [63:0] if_addr = '0;
  logic        if_rsp_valid;
  logic [63:0] if_rdata;
  logic        ls_req_valid = 1'b0;
  logic        ls_req_ready;
  logic [63:0] ls_addr = '0;
  logic        ls_wen = 1'b0;
  logic [7:0]  ls_wmask = '0;
  logic [63:0] ls_wdata = '0;
  logic        ls_rsp_valid;
  logic [63:0] ls_rdata;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [63:0] mem_addr;
  logic        mem_wen;
  logic [7:0]  mem_wmask;
  logic [63:0] mem_wdata;
  logic        mem_rsp_valid = 1'b0;
  logic [63:0] mem_rdata = '0;

  ysyx_22040088_mem_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
    .if_rsp_valid(if_rsp_valid), .if_rdata(if_rdata),
    .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_addr(ls_addr),
    .ls_wen(ls_wen), .ls_wmask(ls_wmask), .ls_wdata(ls_wdata),
    .ls_rsp_valid(ls_rsp_valid), .ls_rdata(ls_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        tie;
    logic        own;     // 0 = IF, 1 = LS
    logic [63:0] addr;
    logic        wen;
    logic [7:0]  wmask;
    logic [63:0] wdata;
    logic [63:0] rdata;   // memory returns this; owner's rdata must show it
    int          rdly;    // cycles mem_req_ready held low in ISSUE
    int          sdly;    // extra WAIT cycles before mem_rsp_valid
    logic        spur;    // pulse mem_rsp_valid in first ISSUE cycle
    logic        wd;      // other requester pulses valid for one busy cycle
    logic        exp_wen;
    logic [7:0]  exp_wmask;
  } vec_t;

  typedef struct {
    logic        own;
    logic [63:0] data;
  } sb_t;

  sb_t         sb[$];
  vec_t        vecs[10];
  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic [63:0] exp_if_rd = '0;
  logic [63:0] exp_ls_rd = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic tie, input logic own, input logic [63:0] addr,
                              input logic wen, input logic [7:0] wmask, input logic [63:0] wdata,
                              input logic [63:0] rdata, input int rdly, input int sdly,
                              input logic spur, input logic wd);
    vec_t v;
    v.tie = tie; v.own = own; v.addr = addr; v.wen = wen; v.wmask = wmask;
    v.wdata = wdata; v.rdata = rdata; v.rdly = rdly; v.sdly = sdly;
    v.spur = spur; v.wd = wd;
    v.exp_wen   = own ? wen : 1'b0;
    v.exp_wmask = own ? wmask : 8'h00;
    return v;
  endfunction

  // Scoreboard: every response pulse must match the oldest accepted request.
  always @(negedge clk) begin
    if (rst && (if_rsp_valid || ls_rsp_valid)) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL sb_unexpected: got if=%b ls=%b expected no response", if_rsp_valid, ls_rsp_valid);
      end else begin
        sb_t e;
        e = sb.pop_front();
        chk("sb_onehot", {63'd0, if_rsp_valid & ls_rsp_valid}, 64'd0);
        chk("sb_owner", {63'd0, ls_rsp_valid}, {63'd0, e.own});
        chk("sb_rdata", e.own ? ls_rdata : if_rdata, e.data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_mem(input vec_t v);
    chk("mem_addr",  mem_addr, v.addr);
    chk("mem_wen",   {63'd0, mem_wen}, {63'd0, v.exp_wen});
    chk("mem_wmask", {56'd0, mem_wmask}, {56'd0, v.exp_wmask});
    if (v.own) chk("mem_wdata", mem_wdata, v.wdata);
  endtask

  task automatic set_other_valid(input logic own, input logic val);
    if (own) if_req_valid = val;
    else     ls_req_valid = val;
  endtask

  task automatic run_txn(input vec_t v);
    int  t_acc;
    sb_t e;
    if_req_valid = 1'b0;
    ls_req_valid = 1'b0;
    if (v.own) begin
      ls_addr = v.addr; ls_wen = v.wen; ls_wmask = v.wmask; ls_wdata = v.wdata;
      ls_req_valid = 1'b1;
      if (v.tie) begin
        if_addr = {$urandom, $urandom};
        if_req_valid = 1'b1;
      end
    end else begin
      if_addr = v.addr;
      if_req_valid = 1'b1;
      if (v.tie) begin
        ls_addr = {$urandom, $urandom}; ls_wen = 1'b1; ls_wmask = 8'hFF;
        ls_wdata = {$urandom, $urandom};
        ls_req_valid = 1'b1;
      end
    end
    #1;
    chk("if_ready", {63'd0, if_req_ready}, {63'd0, ~v.own});
    chk("ls_ready", {63'd0, ls_req_ready}, {63'd0, v.own});
    e.own = v.own;
    e.data = v.rdata;
    sb.push_back(e);
    t_acc = cyc;
    tick();
    // Inputs are don't-care once accepted: scramble them.
    if (v.own) begin
      ls_addr = {$urandom, $urandom}; ls_wen = ~v.wen; ls_wmask = ~v.wmask;
      ls_wdata = {$urandom, $urandom};
      if (!v.tie) ls_req_valid = 1'b0;
    end else begin
      if_addr = {$urandom, $urandom};
      if (!v.tie) if_req_valid = 1'b0;
    end
    #1;
    chk("issue_valid", {63'd0, mem_req_valid}, 64'd1);
    chk_mem(v);
    chk("busy_ready", {62'd0, if_req_ready, ls_req_ready}, 64'd0);
    if (v.spur) begin
      mem_rsp_valid = 1'b1;
      mem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
    end
    if (v.wd) begin
      set_other_valid(v.own, 1'b1);
      #1;
      chk("wd_ready", {62'd0, if_req_ready, ls_req_ready}, 64'd0);
    end
    for (int i = 0; i < v.rdly; i++) begin
      tick();
      mem_rsp_valid = 1'b0;
      if (v.wd) set_other_valid(v.own, 1'b0);
      chk("hold_valid", {63'd0, mem_req_valid}, 64'd1);
      chk_mem(v);
      if (i == 0 && v.spur) begin
        chk("spur_if_rd", if_rdata, exp_if_rd);
        chk("spur_ls_rd", ls_rdata, exp_ls_rd);
        chk("spur_rsp", {62'd0, if_rsp_valid, ls_rsp_valid}, 64'd0);
      end
    end
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    if (v.wd) set_other_valid(v.own, 1'b0);
    chk("wait_valid", {63'd0, mem_req_valid}, 64'd0);
    for (int i = 0; i < v.sdly; i++) begin
      tick();
      chk("wait_rsp", {62'd0, if_rsp_valid, ls_rsp_valid}, 64'd0);
    end
    mem_rsp_valid = 1'b1;
    mem_rdata = v.rdata;
    tick();
    mem_rsp_valid = 1'b0;
    mem_rdata = {$urandom, $urandom};
    chk("rsp_pulse", {62'd0, if_rsp_valid, ls_rsp_valid}, v.own ? 64'd1 : 64'd2);
    chk("latency", 64'(cyc - t_acc), 64'(3 + v.rdly + v.sdly));
    if (v.own) begin
      exp_ls_rd = v.rdata;
      chk("hold_if_rd", if_rdata, exp_if_rd);
    end else begin
      exp_if_rd = v.rdata;
      chk("hold_ls_rd", ls_rdata, exp_ls_rd);
    end
    tick();
    chk("rsp_end", {62'd0, if_rsp_valid, ls_rsp_valid}, 64'd0);
    if (v.wd) begin
      for (int i = 0; i < 3; i++) begin
        tick();
        chk("wd_no_req", {63'd0, mem_req_valid}, 64'd0);
      end
    end
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_req"},   {63'd0, mem_req_valid}, 64'd0);
    chk({nm, "_rsp"},   {62'd0, if_rsp_valid, ls_rsp_valid}, 64'd0);
    chk({nm, "_addr"},  mem_addr, 64'd0);
    chk({nm, "_wen"},   {63'd0, mem_wen}, 64'd0);
    chk({nm, "_wmask"}, {56'd0, mem_wmask}, 64'd0);
    chk({nm, "_wdata"}, mem_wdata, 64'd0);
    chk({nm, "_ifrd"},  if_rdata, 64'd0);
    chk({nm, "_lsrd"},  ls_rdata, 64'd0);
  endtask

  initial begin
    //            tie   own   addr                   wen   wmask  wdata                  rdata                  rd sd spur  wd
    vecs[0] = mk(1'b1, 1'b1, 64'h0000_0000_8000_2000, 1'b0, 8'h00, 64'h0,                 64'h0000_0000_AAAA_0001, 0, 0, 1'b0, 1'b0);
    vecs[1] = mk(1'b1, 1'b0, 64'h0000_0000_8000_2004, 1'b0, 8'h00, 64'h0,                 64'h0000_0000_BBBB_0002, 0, 0, 1'b0, 1'b0);
    vecs[2] = mk(1'b1, 1'b1, 64'h0000_0000_8000_2008, 1'b0, 8'h00, 64'h0,                 64'h0000_0000_CCCC_0003, 1, 0, 1'b0, 1'b0);
    vecs[3] = mk(1'b1, 1'b0, 64'h0000_0000_8000_200C, 1'b0, 8'h00, 64'h0,                 64'h0000_0000_DDDD_0004, 0, 2, 1'b0, 1'b0);
    vecs[4] = mk(1'b0, 1'b0, 64'h0000_0000_8000_0000, 1'b0, 8'h00, 64'h0,                 64'h0000_0000_0010_0073, 0, 0, 1'b0, 1'b0);
    vecs[5] = mk(1'b0, 1'b1, 64'h0000_0000_8000_1000, 1'b1, 8'h0F, 64'h0000_0000_DEAD_BEEF, 64'h0,                  5, 0, 1'b0, 1'b0);
    vecs[6] = mk(1'b0, 1'b0, 64'h0000_0000_8000_0004, 1'b0, 8'h00, 64'h0,                 64'h1234_5678_9ABC_DEF0, 2, 1, 1'b1, 1'b0);
    vecs[7] = mk(1'b0, 1'b0, 64'h0000_0000_8000_0008, 1'b0, 8'h00, 64'h0,                 64'h0000_0000_0000_0013, 1, 0, 1'b0, 1'b1);
    vecs[8] = mk(1'b0, 1'b1, 64'h0000_0000_8000_3000, 1'b0, 8'h00, 64'h0,                 64'hFEDC_BA98_7654_3210, 3, 3, 1'b1, 1'b0);
    vecs[9] = mk(1'b0, 1'b1, 64'h0000_0000_8000_3008, 1'b1, 8'hF0, 64'h1122_3344_5566_7788, 64'h0000_0000_5A5A_A5A5, 1, 1, 1'b0, 1'b0);

    // Reset state
    repeat (2) tick();
    chk_all_zero("reset");
    rst = 1'b1;

    // Table: tie alternation, single fetch, store, spurious, withdraw
    foreach (vecs[i]) run_txn(vecs[i]);

    // Spurious response while idle
    if_req_valid = 1'b0;
    ls_req_valid = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rdata = 64'hDEAD_DEAD_DEAD_DEAD;
    tick();
    mem_rsp_valid = 1'b0;
    tick();
    chk("idle_spur_rsp", {62'd0, if_rsp_valid, ls_rsp_valid}, 64'd0);
    chk("idle_spur_req", {63'd0, mem_req_valid}, 64'd0);
    chk("idle_spur_if_rd", if_rdata, exp_if_rd);
    chk("idle_spur_ls_rd", ls_rdata, exp_ls_rd);

    // Reset while waiting for memory
    if_addr = 64'h0000_0000_8000_4000;
    if_req_valid = 1'b1;
    #1;
    chk("rw_accept", {63'd0, if_req_ready}, 64'd1);
    tick();
    if_req_valid = 1'b0;
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    chk("rw_in_wait", {63'd0, mem_req_valid}, 64'd0);
    rst = 1'b0;
    #1;
    chk_all_zero("rst_async");
    tick();
    rst = 1'b1;
    exp_if_rd = '0;
    exp_ls_rd = '0;
    chk_all_zero("rst_after");
    run_txn(mk(1'b0, 1'b0, 64'h0000_0000_8000_5000, 1'b0, 8'h00, 64'h0, 64'h0000_0000_0000_7777, 0, 0, 1'b0, 1'b0));
    run_txn(mk(1'b1, 1'b1, 64'h0000_0000_8000_6000, 1'b1, 8'h3C, 64'hCAFE_F00D_0000_0001, 64'h0, 0, 1, 1'b0, 1'b0));

    repeat (3) tick();
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
